// File: rtl/switch_debounce2_if.sv
// Switch-conditioner bundle: raw switch inputs in, debounced levels and
// strobes out.
//   sw_a, sw_b            raw, asynchronous, possibly bouncing switch inputs
//   a, b                  debounced synchronous levels (feed comparator a/b)
//   a_rise/a_fall         one-clock edge strobes for channel A
//   b_rise/b_fall         one-clock edge strobes for channel B
//   upd                   one-clock pulse when either level changed
// The master drives the switches; the slave is the conditioner.
interface switch_debounce2_if;
    logic sw_a;
    logic sw_b;
    logic a;
    logic b;
    logic a_rise;
    logic a_fall;
    logic b_rise;
    logic b_fall;
    logic upd;

    modport master (
        output sw_a, sw_b,
        input  a, b, a_rise, a_fall, b_rise, b_fall, upd
    );

    modport slave (
        input  sw_a, sw_b,
        output a, b, a_rise, a_fall, b_rise, b_fall, upd
    );
endinterface

// File: rtl/switch_debounce2.sv
// Dual-channel switch debouncer that sits ahead of the 1-bit comparator.
// Each channel: 2-flop synchronizer, then a counter that must see the
// synchronized input differ from the debounced level for CNT_MAX consecutive
// clocks before the level flips. Edge strobes and upd are registered and
// coincide with the level change.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    switch_debounce2_if.slave (sw_a/sw_b in; a/b, strobes, upd out)
module switch_debounce2 #(
    parameter int CNT_MAX = 1000000,
    parameter int CW      = $clog2(CNT_MAX + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    switch_debounce2_if.slave  bus
);
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

    // Index 0 is channel A, index 1 is channel B.
    logic [1:0]         sw_raw;
    logic [1:0]         s1_q;
    logic [1:0]         s2_q;
    logic [1:0]         lvl_q, lvl_d;
    logic [1:0]         rise_q, rise_d;
    logic [1:0]         fall_q, fall_d;
    logic [1:0][CW-1:0] cnt_q, cnt_d;
    logic               upd_q, upd_d;

    assign sw_raw = {bus.sw_b, bus.sw_a};

    always_comb begin
        lvl_d  = lvl_q;
        cnt_d  = '0;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < 2; i++) begin
            // Any sample equal to the current level leaves cnt_d at zero,
            // so a single-cycle glitch restarts the window.
            if (s2_q[i] != lvl_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    lvl_d[i]  = s2_q[i];
                    rise_d[i] = s2_q[i];
                    fall_d[i] = ~s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
        upd_d = |{rise_d, fall_d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= '0;
            s2_q   <= '0;
            lvl_q  <= '0;
            cnt_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
            upd_q  <= 1'b0;
        end else begin
            s1_q   <= sw_raw;
            s2_q   <= s1_q;
            lvl_q  <= lvl_d;
            cnt_q  <= cnt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            upd_q  <= upd_d;
        end
    end

    assign bus.a      = lvl_q[0];
    assign bus.b      = lvl_q[1];
    assign bus.a_rise = rise_q[0];
    assign bus.a_fall = fall_q[0];
    assign bus.b_rise = rise_q[1];
    assign bus.b_fall = fall_q[1];
    assign bus.upd    = upd_q;

endmodule

// File: tb/tb_switch_debounce2.sv
module tb_switch_debounce2;
    localparam int CNT_MAX = 4;

    logic clk;
    logic rst_n;

    switch_debounce2_if bus ();

    switch_debounce2 #(.CNT_MAX(CNT_MAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a channel flips when the last CNT_MAX synchronized
    // samples seen since its previous flip all differ from its level.
    bit [1:0] m_s1;
    bit [1:0] m_out;
    bit [1:0] m_rise;
    bit [1:0] m_fall;
    bit       m_upd;
    bit       hist_a[$];
    bit       hist_b[$];

    // Strobe counters accumulated per table record.
    int c_ar, c_af, c_br, c_bf, c_up;

    function automatic bit window_ready(input bit q[$], input bit cur);
        if (q.size() < CNT_MAX) return 1'b0;
        for (int k = q.size() - CNT_MAX; k < q.size(); k++)
            if (q[k] == cur) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_s1   = '0;
        m_out  = '0;
        m_rise = '0;
        m_fall = '0;
        m_upd  = 1'b0;
        hist_a.delete();
        hist_b.delete();
    endtask

    task automatic model_edge();
        bit [1:0] raw;
        bit [1:0] s2n;
        bit [1:0] flip;
        if (!rst_n) begin
            model_reset();
            return;
        end
        raw     = {bus.sw_b, bus.sw_a};
        flip[0] = window_ready(hist_a, m_out[0]);
        flip[1] = window_ready(hist_b, m_out[1]);
        s2n     = m_s1;
        m_s1    = raw;
        m_rise  = flip & ~m_out;
        m_fall  = flip & m_out;
        m_out   = m_out ^ flip;
        m_upd   = |flip;
        if (flip[0]) hist_a.delete();
        if (flip[1]) hist_b.delete();
        hist_a.push_back(s2n[0]);
        hist_b.push_back(s2n[1]);
        if (hist_a.size() > CNT_MAX) void'(hist_a.pop_front());
        if (hist_b.size() > CNT_MAX) void'(hist_b.pop_front());
    endtask

    task automatic check_outputs(input string name);
        logic [6:0] got;
        logic [6:0] exp;
        got = {bus.a, bus.b, bus.a_rise, bus.a_fall, bus.b_rise, bus.b_fall, bus.upd};
        exp = {m_out[0], m_out[1], m_rise[0], m_fall[0], m_rise[1], m_fall[1], m_upd};
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: {a,b,ar,af,br,bf,upd} got %b want %b", name, $time, got, exp);
        end
    endtask

    task automatic step(input string name);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(name);
        c_ar += int'(bus.a_rise);
        c_af += int'(bus.a_fall);
        c_br += int'(bus.b_rise);
        c_bf += int'(bus.b_fall);
        c_up += int'(bus.upd);
    endtask

    task automatic cmp_int(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, got, exp);
        end
    endtask

    typedef struct {
        bit sw_a;
        bit sw_b;
        int ncyc;
        bit ea;
        bit eb;
        int ar;
        int af;
        int br;
        int bf;
        int up;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int lat;

        // {sw_a, sw_b, cycles, exp a, exp b, #a_rise, #a_fall, #b_rise, #b_fall, #upd}
        vecs[0]  = '{0, 0, 20, 0, 0, 0, 0, 0, 0, 0};  // idle after reset
        vecs[1]  = '{1, 0,  8, 1, 0, 1, 0, 0, 0, 1};  // clean A rise at edge 6
        vecs[2]  = '{1, 1,  5, 1, 0, 0, 0, 0, 0, 0};  // B not yet through
        vecs[3]  = '{1, 1,  3, 1, 1, 0, 0, 1, 0, 1};  // B rises on 6th edge
        vecs[4]  = '{0, 0,  8, 0, 0, 0, 1, 0, 1, 1};  // both fall together, one upd
        vecs[5]  = '{0, 1,  2, 0, 0, 0, 0, 0, 0, 0};  // B bounce
        vecs[6]  = '{0, 0,  2, 0, 0, 0, 0, 0, 0, 0};
        vecs[7]  = '{0, 1,  2, 0, 0, 0, 0, 0, 0, 0};
        vecs[8]  = '{0, 0,  2, 0, 0, 0, 0, 0, 0, 0};
        vecs[9]  = '{0, 1,  8, 0, 1, 0, 0, 1, 0, 1};  // B settles high
        vecs[10] = '{0, 0,  8, 0, 0, 0, 0, 0, 1, 1};
        vecs[11] = '{1, 1,  8, 1, 1, 1, 0, 1, 0, 1};  // both rise together
        vecs[12] = '{0, 1,  5, 1, 1, 0, 0, 0, 0, 0};  // A fall pending
        vecs[13] = '{0, 1,  3, 0, 1, 0, 1, 0, 0, 1};  // A falls, B stays

        rst_n    = 1'b0;
        bus.sw_a = 1'b0;
        bus.sw_b = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs("reset_state");
        rst_n = 1'b1;

        for (int v = 0; v < 14; v++) begin
            @(negedge clk);
            bus.sw_a = vecs[v].sw_a;
            bus.sw_b = vecs[v].sw_b;
            c_ar = 0; c_af = 0; c_br = 0; c_bf = 0; c_up = 0;
            for (int c = 0; c < vecs[v].ncyc; c++) step($sformatf("vec%0d_cyc", v));
            cmp_int($sformatf("vec%0d_a", v), int'(bus.a), int'(vecs[v].ea));
            cmp_int($sformatf("vec%0d_b", v), int'(bus.b), int'(vecs[v].eb));
            cmp_int($sformatf("vec%0d_a_rise_cnt", v), c_ar, vecs[v].ar);
            cmp_int($sformatf("vec%0d_a_fall_cnt", v), c_af, vecs[v].af);
            cmp_int($sformatf("vec%0d_b_rise_cnt", v), c_br, vecs[v].br);
            cmp_int($sformatf("vec%0d_b_fall_cnt", v), c_bf, vecs[v].bf);
            cmp_int($sformatf("vec%0d_upd_cnt", v), c_up, vecs[v].up);
        end

        // Reset mid-count: A pending rise, B already high; reset clears both
        // immediately, then both rise 6 edges after release.
        @(negedge clk);
        bus.sw_a = 1'b1;
        for (int c = 0; c < 3; c++) step("pre_reset");
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs("async_reset");
        for (int c = 0; c < 2; c++) step("in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            step("post_reset");
            if (bus.a === 1'b1) begin
                lat = c;
                break;
            end
        end
        cmp_int("reset_release_latency", lat, 2 + CNT_MAX);
        cmp_int("reset_release_b", int'(bus.b), 1);

        // Randomized bouncing inputs against the window model.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 5) == 0) bus.sw_a = ~bus.sw_a;
            if ($urandom_range(0, 5) == 0) bus.sw_b = ~bus.sw_b;
            step("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
